heap_array_allocator: RTL and testbench
=======================================

Name: heap_array_allocator

Overview:
- Shared allocator and arbiter for heap array slots: grants array ids, recycles freed ids through a LIFO stack, and maintains the per-array size table.
- Serves NRequesters independent clients (program engines, DMA) through a round-robin req/ack handshake.
- Replaces inline alloc/free and size-update logic in each program engine, so one heap can be shared safely.

Parameters:
- MemoryElementWidth, 12, width of array ids, sizes and indices
- NArrays, 4, number of array slots; must be ≤ 2**MemoryElementWidth
- NRequesters, 2, number of clients; ≥1

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req  input  NRequesters  request, held high until the matching ack is seen
- op  input  NRequesters  per requester: 0 = alloc, 1 = free; stable while req is high
- free_array  input  NRequesters*MemoryElementWidth  id to free; slice r belongs to requester r
- ack  output  NRequesters  one-cycle completion pulse, one-hot
- resp_array  output  MemoryElementWidth  allocated id (alloc) or echoed id (free); valid while ack is high
- resp_error  output  1  error flag for the acked operation; valid while ack is high
- upd_valid  input  1  size-update strobe
- upd_array  input  MemoryElementWidth  array to update
- upd_index  input  MemoryElementWidth  element index written
- size_array  input  MemoryElementWidth  size read address
- size_out  output  MemoryElementWidth  combinational size of size_array; 0 if out of range
- allocs_out  output  MemoryElementWidth  high-water count of slots ever handed out
- free_count  output  MemoryElementWidth  freed-stack depth

Behaviour:
- Reset (async, immediate): all outputs 0, state IDLE, allocs = 0, stack empty, in-use bitmap 0, size table 0, round-robin pointer = 0.
  - Reset mid-operation abandons the operation; no ack is issued.
- FSM: IDLE → EXEC → DONE → IDLE.
  - IDLE: if any req is high, latch the winner (first high req at or after the pointer, wrapping) and go to EXEC; otherwise stay in IDLE.
  - EXEC: perform the operation and register resp_array, resp_error and ack[winner]; go to DONE.
  - DONE: ack is high for exactly this cycle; requests are not sampled; pointer = winner + 1 mod NRequesters; go to IDLE.
- Latency: req sampled at edge k produces ack high in cycle k+2. Back-to-back throughput is one operation per 3 cycles.
- Requester contract: deassert req at the edge after ack. A req still high in IDLE is treated as a new request.
- Alloc:
  - Stack non-empty: pop the top id.
  - Else if allocs < NArrays: id = allocs, then allocs += 1.
  - Else: resp_error = 1, resp_array = 0, no state change.
  - On success: set the in-use bit and clear size[id] to 0.
- Free:
  - id ≥ allocs or in-use bit clear (double free): resp_error = 1, no state change.
  - Else: clear the in-use bit and push id. The stack cannot overflow because frees are bounded by allocs.
  - size[id] is not cleared on free.
- Size update (independent of the FSM, applied every cycle): if upd_valid and upd_array < NArrays and size[upd_array] < upd_index + 1, then size[upd_array] = upd_index + 1.
  - Computed in MemoryElementWidth+1 bits; saturates at 2**MemoryElementWidth − 1.
  - Updates to arrays that are not in use are still applied.
- Simultaneous events: an alloc clearing size[id] in EXEC wins over an upd to the same id in that cycle. An upd to a different id applies normally.
- size_out is combinational; it reflects table updates from the next cycle onward.

Test Plan:
- Reset, then r0 issues alloc ×3 → resp_array 0, 1, 2; each ack arrives 2 cycles after req; allocs_out = 3, free_count = 0.
- Free 1, then alloc → resp_array 1 (LIFO reuse). Free 2, free 0, alloc, alloc → 0 then 2; free_count returns to 0.
- Alloc ×4, then a 5th alloc → resp_error = 1, resp_array = 0, allocs_out stays 4.
- Free 3 twice → first ack resp_error = 0, second resp_error = 1. Free 7 → resp_error = 1.
- r0 and r1 hold alloc continuously (dropping req after each ack, then re-raising) → acks alternate r0, r1, r0, r1, with r0 first after reset.
- Alloc id 0; upd (0, 2) → size_out 3; upd (0, 0) → size_out still 3; free 0 and re-alloc → size_out 0. Upd to id 0 in the same cycle as EXEC of the alloc → size_out 0.

Source files
------------

// File: rtl/heap_array_allocator.sv
// Shared heap array-slot allocator: round-robin arbitration of alloc/free requests,
// LIFO recycling of freed ids, and a per-array size table with max-index tracking.
module heap_array_allocator #(
  parameter int MemoryElementWidth = 12,
  parameter int NArrays            = 4,
  parameter int NRequesters        = 2
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [NRequesters-1:0]                  req,
  input  logic [NRequesters-1:0]                  op,
  input  logic [NRequesters*MemoryElementWidth-1:0] free_array,
  output logic [NRequesters-1:0]                  ack,
  output logic [MemoryElementWidth-1:0]           resp_array,
  output logic                                    resp_error,
  input  logic                                    upd_valid,
  input  logic [MemoryElementWidth-1:0]           upd_array,
  input  logic [MemoryElementWidth-1:0]           upd_index,
  input  logic [MemoryElementWidth-1:0]           size_array,
  output logic [MemoryElementWidth-1:0]           size_out,
  output logic [MemoryElementWidth-1:0]           allocs_out,
  output logic [MemoryElementWidth-1:0]           free_count
);

  localparam int W  = MemoryElementWidth;
  localparam int AW = (NArrays > 1) ? $clog2(NArrays) : 1;
  localparam int RW = (NRequesters > 1) ? $clog2(NRequesters) : 1;
  localparam logic [W:0]  NARR = (W+1)'(NArrays);
  localparam logic [RW:0] NREQ = (RW+1)'(NRequesters);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t state, state_next;

  logic [RW-1:0] ptr;
  logic [RW-1:0] winner;
  logic [RW-1:0] pick;
  logic          any_req;
  logic [RW:0]   arb_sum;
  logic [RW:0]   win_inc;

  logic [W:0]    allocs;
  logic [W:0]    depth;
  logic [W-1:0]  stack [NArrays];
  logic [NArrays-1:0] in_use;
  logic [W-1:0]  size_tbl [NArrays];

  logic [W-1:0]  free_ids [NRequesters];
  logic          op_sel;
  logic [W-1:0]  free_id;
  logic [W-1:0]  top_id;
  logic [W-1:0]  exec_id;
  logic [AW-1:0] exec_idx;
  logic          exec_err;
  logic          alloc_pop;
  logic          alloc_new;
  logic          alloc_ok;
  logic          free_ok;

  logic [W:0]    upd_sum;
  logic [W-1:0]  upd_new;
  logic [W-1:0]  upd_cur;
  logic [AW-1:0] upd_idx;
  logic          upd_grow;

  always_comb begin
    for (int r = 0; r < NRequesters; r++) begin
      free_ids[r] = free_array[r*W +: W];
    end
  end

  // Scan from the pointer upward; descending loop so the smallest offset wins.
  always_comb begin
    any_req = 1'b0;
    pick    = ptr;
    arb_sum = '0;
    for (int i = NRequesters - 1; i >= 0; i--) begin
      arb_sum = {1'b0, ptr} + (RW+1)'(i);
      if (arb_sum >= NREQ) begin
        arb_sum = arb_sum - NREQ;
      end
      if (req[arb_sum[RW-1:0]]) begin
        any_req = 1'b1;
        pick    = arb_sum[RW-1:0];
      end
    end
  end

  assign win_inc = {1'b0, winner} + (RW+1)'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    op_sel     = op[winner];
    free_id    = free_ids[winner];
    top_id     = stack[AW'(depth - (W+1)'(1))];
    exec_id    = '0;
    exec_err   = 1'b0;
    alloc_pop  = 1'b0;
    alloc_new  = 1'b0;
    free_ok    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = DONE;
        if (!op_sel) begin
          if (depth != '0) begin
            alloc_pop = 1'b1;
            exec_id   = top_id;
          end else if (allocs < NARR) begin
            alloc_new = 1'b1;
            exec_id   = allocs[W-1:0];
          end else begin
            exec_err = 1'b1;
          end
        end else begin
          exec_id = free_id;
          if (({1'b0, free_id} >= allocs) || !in_use[AW'(free_id)]) begin
            exec_err = 1'b1;
          end else begin
            free_ok = 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign alloc_ok = alloc_pop | alloc_new;
  assign exec_idx = AW'(exec_id);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr        <= '0;
      winner     <= '0;
      allocs     <= '0;
      depth      <= '0;
      in_use     <= '0;
      ack        <= '0;
      resp_array <= '0;
      resp_error <= 1'b0;
      for (int k = 0; k < NArrays; k++) begin
        stack[k] <= '0;
      end
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            winner <= pick;
          end
        end
        EXEC: begin
          ack[winner] <= 1'b1;
          resp_array  <= exec_id;
          resp_error  <= exec_err;
          if (alloc_pop) begin
            depth <= depth - (W+1)'(1);
          end
          if (alloc_new) begin
            allocs <= allocs + (W+1)'(1);
          end
          if (alloc_ok) begin
            in_use[exec_idx] <= 1'b1;
          end
          if (free_ok) begin
            in_use[exec_idx]     <= 1'b0;
            stack[AW'(depth)]    <= exec_id;
            depth                <= depth + (W+1)'(1);
          end
        end
        DONE: begin
          ptr <= (win_inc >= NREQ) ? '0 : win_inc[RW-1:0];
        end
        default: begin
        end
      endcase
    end
  end

  // Size grows to the highest index written plus one, saturating at the width limit.
  assign upd_sum  = {1'b0, upd_index} + (W+1)'(1);
  assign upd_new  = upd_sum[W] ? '1 : upd_sum[W-1:0];
  assign upd_idx  = AW'(upd_array);
  assign upd_cur  = size_tbl[upd_idx];
  assign upd_grow = upd_valid && ({1'b0, upd_array} < NARR) && ({1'b0, upd_cur} < upd_sum);

  // An alloc clearing an entry takes priority over a same-cycle update to it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < NArrays; j++) begin
        size_tbl[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NArrays; j++) begin
        if (alloc_ok && (exec_idx == AW'(j))) begin
          size_tbl[j] <= '0;
        end else if (upd_grow && (upd_idx == AW'(j))) begin
          size_tbl[j] <= upd_new;
        end
      end
    end
  end

  assign size_out   = ({1'b0, size_array} < NARR) ? size_tbl[AW'(size_array)] : '0;
  assign allocs_out = allocs[W-1:0];
  assign free_count = depth[W-1:0];

endmodule

// File: tb/tb_heap_array_allocator.sv
// Directed self-checking bench for heap_array_allocator: alloc/free/LIFO reuse,
// exhaustion and double-free errors, round-robin fairness and size-table behaviour.
module tb_heap_array_allocator;

  logic        clock;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  op;
  logic [23:0] free_array;
  logic [1:0]  ack;
  logic [11:0] resp_array;
  logic        resp_error;
  logic        upd_valid;
  logic [11:0] upd_array;
  logic [11:0] upd_index;
  logic [11:0] size_array;
  logic [11:0] size_out;
  logic [11:0] allocs_out;
  logic [11:0] free_count;

  int checks = 0;
  int errors = 0;

  heap_array_allocator #(
    .MemoryElementWidth(12),
    .NArrays(4),
    .NRequesters(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req(req),
    .op(op),
    .free_array(free_array),
    .ack(ack),
    .resp_array(resp_array),
    .resp_error(resp_error),
    .upd_valid(upd_valid),
    .upd_array(upd_array),
    .upd_index(upd_index),
    .size_array(size_array),
    .size_out(size_out),
    .allocs_out(allocs_out),
    .free_count(free_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic doReset();
    reset      = 1'b1;
    req        = '0;
    op         = '0;
    free_array = '0;
    upd_valid  = 1'b0;
    upd_array  = '0;
    upd_index  = '0;
    size_array = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Issue one request from requester r; optionally pulse an update (id 0, index 9) during EXEC.
  task automatic applyStimulus(input int r, input logic o, input logic [11:0] id, input bit upd_exec,
                               output logic [11:0] rid, output logic rerr);
    int  lat;
    bit  seen;
    @(negedge clock);
    req[r] = 1'b1;
    op[r]  = o;
    free_array[r*12 +: 12] = id;
    lat  = 0;
    seen = 0;
    rid  = '0;
    rerr = 1'b0;
    while (!seen && lat < 10) begin
      @(negedge clock);
      lat++;
      if (lat == 1 && upd_exec) begin
        checkOutput("no_early_ack", 32'(ack), 0);
        upd_valid = 1'b1;
        upd_array = 12'd0;
        upd_index = 12'd9;
      end else begin
        upd_valid = 1'b0;
      end
      if (ack != '0) begin
        seen = 1;
        rid  = resp_array;
        rerr = resp_error;
        checkOutput("ack_onehot", 32'(ack), 32'(1) << r);
        checkOutput("latency", 32'(lat), 2);
      end
    end
    upd_valid = 1'b0;
    if (!seen) checkOutput("ack_timeout", 0, 1);
    req[r] = 1'b0;
  endtask

  task automatic doUpdate(input logic [11:0] a, input logic [11:0] idx);
    @(negedge clock);
    upd_valid = 1'b1;
    upd_array = a;
    upd_index = idx;
    @(negedge clock);
    upd_valid = 1'b0;
  endtask

  logic [11:0] rid;
  logic        rerr;
  logic [1:0]  exp_ack [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [11:0] exp_rr_id [4] = '{12'd0, 12'd1, 12'd2, 12'd3};

  initial begin
    doReset();
    checkOutput("rst_ack", 32'(ack), 0);
    checkOutput("rst_resp", 32'(resp_array), 0);
    checkOutput("rst_err", 32'(resp_error), 0);
    checkOutput("rst_allocs", 32'(allocs_out), 0);
    checkOutput("rst_free", 32'(free_count), 0);
    checkOutput("rst_size", 32'(size_out), 0);

    // Fresh allocations hand out ids in order
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1'b0, 12'd0, 0, rid, rerr);
      checkOutput("alloc_id", 32'(rid), 32'(i));
      checkOutput("alloc_err", 32'(rerr), 0);
    end
    checkOutput("allocs3", 32'(allocs_out), 3);
    checkOutput("free0", 32'(free_count), 0);

    // LIFO reuse
    applyStimulus(0, 1'b1, 12'd1, 0, rid, rerr);
    checkOutput("free1_err", 32'(rerr), 0);
    checkOutput("free1_echo", 32'(rid), 1);
    checkOutput("free_cnt1", 32'(free_count), 1);
    applyStimulus(0, 1'b0, 12'd0, 0, rid, rerr);
    checkOutput("reuse1", 32'(rid), 1);
    applyStimulus(0, 1'b1, 12'd2, 0, rid, rerr);
    applyStimulus(0, 1'b1, 12'd0, 0, rid, rerr);
    checkOutput("free_cnt2", 32'(free_count), 2);
    applyStimulus(0, 1'b0, 12'd0, 0, rid, rerr);
    checkOutput("lifo_a", 32'(rid), 0);
    applyStimulus(0, 1'b0, 12'd0, 0, rid, rerr);
    checkOutput("lifo_b", 32'(rid), 2);
    checkOutput("free_cnt0", 32'(free_count), 0);
    checkOutput("allocs_still3", 32'(allocs_out), 3);

    // Exhaustion and free errors
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1'b0, 12'd0, 0, rid, rerr);
      checkOutput("fill_id", 32'(rid), 32'(i));
    end
    applyStimulus(0, 1'b0, 12'd0, 0, rid, rerr);
    checkOutput("full_err", 32'(rerr), 1);
    checkOutput("full_resp", 32'(rid), 0);
    checkOutput("full_allocs", 32'(allocs_out), 4);
    applyStimulus(1, 1'b1, 12'd3, 0, rid, rerr);
    checkOutput("free3_err", 32'(rerr), 0);
    applyStimulus(1, 1'b1, 12'd3, 0, rid, rerr);
    checkOutput("dbl_free_err", 32'(rerr), 1);
    checkOutput("dbl_free_echo", 32'(rid), 3);
    applyStimulus(1, 1'b1, 12'd7, 0, rid, rerr);
    checkOutput("free7_err", 32'(rerr), 1);
    checkOutput("free7_echo", 32'(rid), 7);
    checkOutput("free_cnt_err", 32'(free_count), 1);

    // Round-robin: both requesters hold alloc requests
    doReset();
    @(negedge clock);
    req = 2'b11;
    op  = 2'b00;
    for (int n = 0; n < 4; n++) begin
      int  waited;
      waited = 0;
      while (ack == '0 && waited < 10) begin
        @(negedge clock);
        waited++;
      end
      checkOutput("rr_ack", 32'(ack), 32'(exp_ack[n]));
      checkOutput("rr_id", 32'(resp_array), 32'(exp_rr_id[n]));
      req = req & ~ack;
      @(negedge clock);
      req = 2'b11;
    end
    req = 2'b00;

    // Size table
    doReset();
    applyStimulus(0, 1'b0, 12'd0, 0, rid, rerr);
    size_array = 12'd0;
    doUpdate(12'd0, 12'd2);
    checkOutput("size_grow", 32'(size_out), 3);
    doUpdate(12'd0, 12'd0);
    checkOutput("size_keep", 32'(size_out), 3);
    applyStimulus(0, 1'b1, 12'd0, 0, rid, rerr);
    checkOutput("size_after_free", 32'(size_out), 3);
    applyStimulus(0, 1'b0, 12'd0, 0, rid, rerr);
    checkOutput("realloc_id", 32'(rid), 0);
    checkOutput("size_cleared", 32'(size_out), 0);
    doUpdate(12'd0, 12'd4);
    checkOutput("size_5", 32'(size_out), 5);
    applyStimulus(0, 1'b1, 12'd0, 0, rid, rerr);
    applyStimulus(0, 1'b0, 12'd0, 1, rid, rerr);
    checkOutput("race_id", 32'(rid), 0);
    checkOutput("race_size", 32'(size_out), 0);
    doUpdate(12'd2, 12'd6);
    size_array = 12'd2;
    #1;
    checkOutput("size_unused", 32'(size_out), 7);
    doUpdate(12'd1, 12'd4095);
    size_array = 12'd1;
    #1;
    checkOutput("size_sat", 32'(size_out), 4095);
    doUpdate(12'd5, 12'd3);
    size_array = 12'd5;
    #1;
    checkOutput("size_oob", 32'(size_out), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
